// File: rtl/sensor_pkg.sv
// Shared definitions for the ultrasonic ranging front end: FSM state
// encoding, clock frequency and the default tick counts derived from it.
package sensor_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } ping_state_t;

  localparam int unsigned CLK_FREQ_HZ = 12_000_000;

  // Convert a time in microseconds to clk cycles at CLK_FREQ_HZ.
  function automatic int unsigned us_to_ticks(input int unsigned us);
    return (CLK_FREQ_HZ / 1_000_000) * us;
  endfunction

  // Convert a time in milliseconds to clk cycles at CLK_FREQ_HZ.
  function automatic int unsigned ms_to_ticks(input int unsigned ms);
    return (CLK_FREQ_HZ / 1_000) * ms;
  endfunction

  // Sensor timing: 10 us trigger, 60 ms repetition, 25 ms per-phase timeout.
  localparam int unsigned DEF_TRIG_TICKS    = us_to_ticks(10);
  localparam int unsigned DEF_PERIOD_TICKS  = ms_to_ticks(60);
  localparam int unsigned DEF_TIMEOUT_TICKS = ms_to_ticks(25);
  localparam int unsigned DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/echo_sync_edge.sv
// Multi-flop synchronizer for an asynchronous sensor pin, with the
// synchronized level and single-cycle rise/fall pulses derived from it.
// SYNC_STAGES must be at least 2.
module echo_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;

  // Shift the raw pin through the synchronizer and keep a one-cycle-old copy
  // of the last stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      level_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

endmodule

// File: rtl/ultrasonic_ping_scheduler.sv
// Ping scheduler for the ultrasonic ranging sensor: issues the trigger,
// times the echo, enforces the repetition period and publishes the width.
//
// Output protocol: width_valid and timeout_err are one-cycle strobes with no
// ready/back-pressure; the consumer must take echo_width in the cycle
// width_valid is high. echo_width holds its value until the next valid ping,
// so a timeout leaves the last good width on the bus. The two strobes are
// mutually exclusive and ping_count advances in the same cycle as either.
module ultrasonic_ping_scheduler
  import sensor_pkg::*;
#(
  parameter int unsigned TRIG_TICKS    = DEF_TRIG_TICKS,
  parameter int unsigned PERIOD_TICKS  = DEF_PERIOD_TICKS,
  parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        echo_in,
  output logic        trig_out,
  output logic [31:0] echo_width,
  output logic        width_valid,
  output logic        timeout_err,
  output logic        busy,
  output logic [15:0] ping_count,
  output ping_state_t state_dbg
);

  localparam logic [31:0] TRIG_LAST   = 32'(TRIG_TICKS - 1);
  localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_TICKS - 1);
  localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_TICKS - 1);
  localparam logic [31:0] WIDTH_MAX   = 32'(TIMEOUT_TICKS);

  ping_state_t state, state_next;

  logic        echo_s;
  logic        echo_rise;
  logic        echo_fall;

  // tmo_cnt times the trigger pulse in S_TRIG and the rise wait in S_WAIT_RISE.
  logic [31:0] tmo_cnt;
  logic [31:0] width_cnt;
  logic [31:0] period_cnt;

  // Control decoded by the FSM and applied to the datapath registers.
  logic clr_period;
  logic clr_tmo;
  logic inc_tmo;
  logic start_width;
  logic inc_width;
  logic capture;
  logic timeout_hit;

  echo_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_echo_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (echo_in),
    .level    (echo_s),
    .rise     (echo_rise),
    .fall     (echo_fall)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control; edge events win over timeouts in the
  // same cycle so a just-in-time echo is still measured.
  always_comb begin
    state_next  = state;
    clr_period  = 1'b0;
    clr_tmo     = 1'b0;
    inc_tmo     = 1'b0;
    start_width = 1'b0;
    inc_width   = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) begin
          state_next = S_TRIG;
          clr_period = 1'b1;
          clr_tmo    = 1'b1;
        end
      end
      S_TRIG: begin
        if (tmo_cnt == TRIG_LAST) begin
          state_next = S_WAIT_RISE;
          clr_tmo    = 1'b1;
        end else begin
          inc_tmo = 1'b1;
        end
      end
      S_WAIT_RISE: begin
        // Only an edge starts a measurement; a level left high by a stuck
        // echo from the previous ping is ignored.
        if (echo_rise) begin
          state_next  = S_MEASURE;
          start_width = 1'b1;
          clr_tmo     = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next  = S_HOLDOFF;
          timeout_hit = 1'b1;
        end else begin
          inc_tmo = 1'b1;
        end
      end
      S_MEASURE: begin
        if (echo_fall) begin
          state_next = S_HOLDOFF;
          capture    = 1'b1;
        end else if (width_cnt == WIDTH_MAX) begin
          state_next  = S_HOLDOFF;
          timeout_hit = 1'b1;
        end else if (echo_s) begin
          inc_width = 1'b1;
        end
      end
      S_HOLDOFF: begin
        // Re-triggering straight from here keeps trigger rises exactly
        // PERIOD_TICKS apart under a steady enable.
        if (period_cnt >= PERIOD_LAST) begin
          if (enable) begin
            state_next = S_TRIG;
            clr_period = 1'b1;
            clr_tmo    = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Phase counters: period from trigger rise, trigger/rise-wait timer, and
  // echo width (which cannot pass WIDTH_MAX, so it never wraps).
  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt <= '0;
      tmo_cnt    <= '0;
      width_cnt  <= '0;
    end else begin
      if (clr_period) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + 32'd1;
      end

      if (clr_tmo) begin
        tmo_cnt <= '0;
      end else if (inc_tmo) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end

      if (start_width) begin
        width_cnt <= 32'd1;
      end else if (inc_width) begin
        width_cnt <= width_cnt + 32'd1;
      end
    end
  end

  // Registered outputs: pin levels follow the next state so they change on
  // the same edge as the state register, and strobes fire one cycle after
  // the deciding event.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_out    <= 1'b0;
      busy        <= 1'b0;
      echo_width  <= '0;
      width_valid <= 1'b0;
      timeout_err <= 1'b0;
      ping_count  <= '0;
    end else begin
      trig_out    <= (state_next == S_TRIG);
      busy        <= (state_next != S_IDLE);
      width_valid <= capture;
      timeout_err <= timeout_hit;
      if (capture) begin
        echo_width <= width_cnt;
      end
      if (capture || timeout_hit) begin
        ping_count <= ping_count + 16'd1;
      end
    end
  end

  assign state_dbg = state;

endmodule
